pe_out_drain: RTL

PE_OUT_DRAIN -- requirements
Module: pe_out_drain

---
 rtl/pe_out_drain.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pe_out_drain.sv
// pe_out_drain: captures the four accumulator outputs of a linear PE row on
// the falling edge of the fire strobe and serializes them as a valid/ready
// word stream, column 0 first.
//
// Handshake: a word moves on every rising edge where out_valid and
// out_ready are both high. out_data, out_idx and out_valid stay stable while
// the word waits. out_valid is high only in DRAIN. out_ready is ignored in
// IDLE.
//
// Optional feature: define PE_DRAIN_RELU_EN to clamp negative (MSB set)
// values to zero at capture. Without it, values are stored bit for bit.
// dbg_state_o exposes the FSM state: 0 = IDLE, 1 = DRAIN.
module pe_out_drain #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fire,
  input  logic [DW-1:0] pe_o1,
  input  logic [DW-1:0] pe_o2,
  input  logic [DW-1:0] pe_o3,
  input  logic [DW-1:0] pe_o4,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          ovr,
  input  logic          ovr_clr,
  output logic          dbg_state_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          fire_q;
  logic [1:0]    idx_q, idx_d;
  logic [DW-1:0] buf_q [4];
  logic [DW-1:0] buf_d [4];
  logic          ovr_q, ovr_d;
  logic          capture;
  logic          load;
  logic          ovr_set;

  // The value that goes into the buffer for one PE output.
  function automatic logic [DW-1:0] store_val(input logic [DW-1:0] v);
`ifdef PE_DRAIN_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // A frame is ready when the fire strobe falls.
  assign capture = fire_q & ~fire;

  // Next state, buffer load, index advance and overrun detection.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovr_d   = ovr_q;
    buf_d   = buf_q;
    load    = 1'b0;
    ovr_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (capture) begin
          load    = 1'b1;
          idx_d   = 2'd0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_q == 2'd3) begin
            // Last word leaves; a capture on this edge starts the next
            // frame without an idle cycle.
            idx_d = 2'd0;
            if (capture) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
            if (capture) begin
              ovr_set = 1'b1;
            end
          end
        end else if (capture) begin
          ovr_set = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase

    if (load) begin
      buf_d[0] = store_val(pe_o1);
      buf_d[1] = store_val(pe_o2);
      buf_d[2] = store_val(pe_o3);
      buf_d[3] = store_val(pe_o4);
    end

    // A new overrun takes priority over a clear on the same edge.
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  // State, index, buffer, fire history and overrun flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      fire_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fire_q  <= fire;
      ovr_q   <= ovr_d;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign out_valid   = (state_q == DRAIN);
  assign busy        = (state_q == DRAIN);
  assign out_idx     = idx_q;
  assign out_data    = buf_q[idx_q];
  assign out_last    = (state_q == DRAIN) && (idx_q == 2'd3);
  assign ovr         = ovr_q;
  assign dbg_state_o = state_q;

endmodule
